noc_traffic_node: RTL and testbench

//  Parametrised, synthesisable traffic generator and checker for one node of the NxN mesh.

---
 rtl/noc_traffic_node.sv | 184 ++++++++++++++++++
 tb/tb_noc_traffic_node.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_node.sv
// Per-node mesh traffic generator and ejection checker.
// Injects sequence-numbered flits to a programmable destination; scores received flits per source.
module noc_traffic_node #(
  parameter int unsigned MESH_X  = 4,
  parameter int unsigned MESH_Y  = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned PAY_W   = 8,
  parameter int unsigned NODE_ID = 0,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned FLIT_W  = 2 * ID_W + PAY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ID_W-1:0]   fixed_dest,
  input  logic [3:0]        gap,
  input  logic [15:0]       num_pkts,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic [15:0]       err_count
);

  localparam int unsigned NODES     = MESH_X * MESH_Y;
  localparam int unsigned COMP_INT  = ((1 << ID_W) - 1 - NODE_ID) % NODES;
  localparam int unsigned TRANS_INT = (MESH_X == MESH_Y) ?
                                      ((NODE_ID % MESH_X) * MESH_X + NODE_ID / MESH_X) : COMP_INT;
  localparam logic [ID_W-1:0] SELF_ID   = ID_W'(NODE_ID);
  localparam logic [ID_W-1:0] NEXT_ID   = ID_W'((NODE_ID + 1) % NODES);
  localparam logic [ID_W-1:0] COMP_DST  = ID_W'(COMP_INT);
  localparam logic [ID_W-1:0] TRANS_DST = ID_W'(TRANS_INT);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       num_q, num_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        gap_q, gap_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]   fixed_q, fixed_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic [15:0]       rx_count_q, rx_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [PAY_W-1:0]  tx_seq_q [NODES];
  logic [PAY_W-1:0]  tx_seq_d [NODES];
  logic [PAY_W-1:0]  exp_seq_q [NODES];
  logic [PAY_W-1:0]  exp_seq_d [NODES];

  logic [ID_W-1:0]   raw_dst, tx_dst;
  logic [15:0]       lfsr_step;
  logic [ID_W-1:0]   rx_src, rx_dst;
  logic [PAY_W-1:0]  rx_pay;
  logic              src_ok, rx_err;

  // Galois form, taps 16,14,13,11, shifting right.
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    unique case (mode_q)
      2'd0:    raw_dst = fixed_q;
      2'd1:    raw_dst = ID_W'(32'(lfsr_q[ID_W-1:0]) % NODES);
      2'd2:    raw_dst = COMP_DST;
      default: raw_dst = TRANS_DST;
    endcase
    tx_dst = (raw_dst == SELF_ID) ? NEXT_ID : raw_dst;
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    num_d      = num_q;
    mode_d     = mode_q;
    gap_d      = gap_q;
    fixed_d    = fixed_q;
    gap_cnt_d  = gap_cnt_q;
    tx_count_d = tx_count_q;
    tx_seq_d   = tx_seq_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_d      = num_pkts;
          mode_d     = mode;
          gap_d      = gap;
          fixed_d    = fixed_dest;
          tx_count_d = '0;
          gap_cnt_d  = '0;
          state_d    = (num_pkts == 16'd0) ? StDone : StSend;
        end
      end
      StSend: begin
        if (tx_ready) begin
          tx_count_d       = tx_count_q + 16'd1;
          tx_seq_d[tx_dst] = tx_seq_q[tx_dst] + PAY_W'(1);
          lfsr_d           = lfsr_step;
          gap_cnt_d        = '0;
          if (tx_count_d == num_q) begin
            state_d = StDone;
          end else if (gap_q != 4'd0) begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == gap_q - 4'd1) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_src = rx_flit[FLIT_W-1 -: ID_W];
  assign rx_dst = rx_flit[PAY_W +: ID_W];
  assign rx_pay = rx_flit[PAY_W-1:0];
  assign src_ok = 32'(rx_src) < NODES;
  assign rx_err = (rx_dst != SELF_ID) || !src_ok || (rx_pay != exp_seq_q[rx_src]);

  always_comb begin
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    exp_seq_d   = exp_seq_q;
    if (rx_valid) begin
      rx_count_d = rx_count_q + 16'd1;
      if (rx_err && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end
      // Resync on every in-range source so one dropped flit costs a single error.
      if (src_ok) begin
        exp_seq_d[rx_src] = rx_pay + PAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lfsr_q      <= SEED;
      num_q       <= '0;
      mode_q      <= '0;
      gap_q       <= '0;
      fixed_q     <= '0;
      gap_cnt_q   <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      for (int unsigned i = 0; i < NODES; i++) begin
        tx_seq_q[i]  <= '0;
        exp_seq_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      gap_q       <= gap_d;
      fixed_q     <= fixed_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      tx_seq_q    <= tx_seq_d;
      exp_seq_q   <= exp_seq_d;
    end
  end

  assign tx_valid  = (state_q == StSend);
  assign tx_flit   = tx_valid ? {SELF_ID, tx_dst, tx_seq_q[tx_dst]} : '0;
  assign busy      = (state_q == StSend) || (state_q == StGap);
  assign done      = (state_q == StDone);
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_noc_traffic_node.sv
// Randomized bench for noc_traffic_node against a transaction-level reference model.
// A second instance at node 6 covers the transpose destination.
module tb_noc_traffic_node;

  localparam int NODES = 16;
  localparam int NODE  = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  fixed_dest;
  logic [3:0]  gap;
  logic [15:0] num_pkts;
  logic        tx_ready, rx_valid;
  logic [15:0] rx_flit;
  logic [15:0] tx_flit, tx_count, rx_count, err_count;
  logic        tx_valid, busy, done;
  logic [15:0] tx_flit6, tx_count6, rx_count6, err_count6;
  logic        tx_valid6, busy6, done6;

  noc_traffic_node #(.NODE_ID(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_dest(fixed_dest), .gap(gap),
    .num_pkts(num_pkts), .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .busy(busy), .done(done), .tx_count(tx_count),
    .rx_count(rx_count), .err_count(err_count)
  );

  noc_traffic_node #(.NODE_ID(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_dest(fixed_dest), .gap(gap),
    .num_pkts(num_pkts), .tx_flit(tx_flit6), .tx_valid(tx_valid6), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .busy(busy6), .done(done6), .tx_count(tx_count6),
    .rx_count(rx_count6), .err_count(err_count6)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_run, m_done;
  int          m_cnt, m_num, m_wait, m_mode, m_gap, m_fixed, m_rxc, m_err;
  logic [15:0] m_lfsr;
  logic [7:0]  m_txseq [NODES];
  logic [7:0]  m_exp   [NODES];

  logic [15:0] hist[$];
  int          hist_t[$];
  logic [15:0] hist6[$];
  logic [15:0] want[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int m_dst();
    int d;
    case (m_mode)
      0:       d = m_fixed;
      1:       d = int'(m_lfsr[3:0]) % NODES;
      2:       d = (15 - NODE) % NODES;
      default: d = (NODE % 4) * 4 + NODE / 4;
    endcase
    if (d == NODE) d = (NODE + 1) % NODES;
    return d;
  endfunction

  function automatic logic [15:0] m_flit();
    int d = m_dst();
    return {4'(NODE), 4'(d), m_txseq[d]};
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_cnt = 0; m_num = 0; m_wait = 0;
    m_mode = 0; m_gap = 0; m_fixed = 0; m_rxc = 0; m_err = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < NODES; i++) begin
      m_txseq[i] = 8'd0;
      m_exp[i]   = 8'd0;
    end
  endtask

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_edge();
    int d;
    int src, dst;
    logic [7:0] pay;
    bit bad;
    if (tx_valid && tx_ready) begin
      hist.push_back(tx_flit);
      hist_t.push_back(cyc);
    end
    if (tx_valid6 && tx_ready) hist6.push_back(tx_flit6);
    if (m_run) begin
      if (m_wait > 0) m_wait--;
      else if (tx_ready) begin
        d = m_dst();
        m_txseq[d] = m_txseq[d] + 8'd1;
        m_lfsr = lfsr_next(m_lfsr);
        m_cnt++;
        if (m_cnt == m_num) begin
          m_run = 0;
          m_done = 1;
        end else m_wait = m_gap;
      end
    end else if (start) begin
      m_mode = mode; m_gap = gap; m_fixed = fixed_dest; m_num = num_pkts;
      m_cnt = 0; m_wait = 0;
      if (m_num == 0) m_done = 1;
      else begin
        m_run = 1;
        m_done = 0;
      end
    end
    if (rx_valid) begin
      src = rx_flit[15:12];
      dst = rx_flit[11:8];
      pay = rx_flit[7:0];
      m_rxc = (m_rxc + 1) % 65536;
      bad = (dst != NODE) || (src >= NODES) || (pay != m_exp[src]);
      if (bad && m_err < 65535) m_err++;
      if (src < NODES) m_exp[src] = pay + 8'd1;
    end
  endtask

  task automatic check_outputs();
    bit v = m_run && (m_wait == 0);
    check_eq("tx_valid", tx_valid, v);
    if (v) check_eq("tx_flit", tx_flit, m_flit());
    check_eq("busy", busy, m_run);
    check_eq("done", done, m_done);
    check_eq("tx_count", tx_count, m_cnt);
    check_eq("rx_count", rx_count, m_rxc);
    check_eq("err_count", err_count, m_err);
  endtask

  task automatic tick(input bit rdy, input bit st, input bit rv, input logic [15:0] rf);
    tx_ready = rdy; start = st; rx_valid = rv; rx_flit = rf;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; tx_ready = 0; rx_valid = 0; rx_flit = '0;
    mode = '0; fixed_dest = '0; gap = '0; num_pkts = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_hist();
    hist.delete(); hist_t.delete(); hist6.delete();
  endtask

  task automatic start_run(input int md, input int fd, input int gp, input int np, input bit rdy);
    mode = 2'(md); fixed_dest = 4'(fd); gap = 4'(gp); num_pkts = 16'(np);
    tick(rdy, 1'b1, 1'b0, 16'h0);
  endtask

  // Config inputs are scrambled each cycle to show they are latched only at start.
  task automatic run(input int rdy_pct, input bit rx_on, input int budget);
    int n = 0;
    logic [15:0] rf;
    int s;
    while (m_run && n < budget) begin
      mode = 2'($urandom); gap = 4'($urandom); fixed_dest = 4'($urandom);
      num_pkts = 16'($urandom);
      s  = $urandom_range(NODES - 1);
      rf = {4'(s), ($urandom_range(9) == 0) ? 4'($urandom) : 4'(NODE),
            ($urandom_range(3) == 0) ? 8'($urandom) : m_exp[s]};
      tick($urandom_range(99) < rdy_pct, 1'b0, rx_on && ($urandom_range(1) == 1), rf);
      n++;
    end
    check_eq("run_done", done, 1'b1);
  endtask

  task automatic gen_mode1(input int n);
    logic [15:0] l = 16'hACE1;
    logic [7:0]  sq [NODES];
    int d;
    for (int i = 0; i < NODES; i++) sq[i] = 8'd0;
    want.delete();
    for (int i = 0; i < n; i++) begin
      d = int'(l[3:0]);
      if (d == NODE) d = NODE + 1;
      want.push_back({4'(NODE), 4'(d), sq[d]});
      sq[d] = sq[d] + 8'd1;
      l = lfsr_next(l);
    end
  endtask

  initial begin
    do_reset();

    // Back-to-back fixed destination
    clear_hist();
    start_run(0, 5, 0, 4, 1'b1);
    run(100, 1'b0, 50);
    check_eq("t1_count", hist.size(), 4);
    for (int i = 0; i < hist.size(); i++) begin
      check_eq("t1_flit", hist[i], 16'h0500 + 16'(i));
      check_eq("t1_spacing", hist_t[i] - hist_t[0], i);
    end

    // Stall then gap spacing
    clear_hist();
    start_run(0, 5, 3, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 16'h0);
      check_eq("t2_stall_flit", tx_flit, 16'h0504);
    end
    run(100, 1'b0, 60);
    check_eq("t2_count", hist.size(), 4);
    for (int i = 0; i < hist.size(); i++) begin
      check_eq("t2_flit", hist[i], 16'h0504 + 16'(i));
      if (i > 0) check_eq("t2_gap", hist_t[i] - hist_t[i-1], 4);
    end

    // Destination modes
    clear_hist();
    start_run(2, 0, 1, 3, 1'b1);
    run(70, 1'b0, 80);
    check_eq("t3_m2_count", hist.size(), 3);
    foreach (hist[i]) check_eq("t3_m2_dst", hist[i][11:8], 4'hF);
    clear_hist();
    start_run(3, 0, 0, 3, 1'b1);
    run(70, 1'b0, 80);
    check_eq("t3_m3_count6", hist6.size(), 3);
    foreach (hist6[i]) check_eq("t3_m3_dst6", hist6[i][11:8], 4'd9);
    clear_hist();
    start_run(0, 0, 0, 3, 1'b1);
    run(100, 1'b0, 80);
    foreach (hist[i]) check_eq("t3_noself_dst", hist[i][11:8], 4'd1);

    // Checker sequence, resync and misroute
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 16'h3000);
    tick(1'b0, 1'b0, 1'b1, 16'h3001);
    tick(1'b0, 1'b0, 1'b1, 16'h3003);
    tick(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("t4_rx", rx_count, 3);
    check_eq("t4_err", err_count, 1);
    tick(1'b0, 1'b0, 1'b1, 16'h3004);
    tick(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("t4_resync_err", err_count, 1);
    tick(1'b0, 1'b0, 1'b1, 16'h3205);
    check_eq("t5_misroute_err", err_count, 2);
    clear_hist();
    start_run(0, 5, 0, 0, 1'b1);
    check_eq("t5_zero_done", done, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("t5_zero_none", hist.size(), 0);

    // LFSR mode, async reset mid-run, repeatable restart
    gen_mode1(6);
    do_reset();
    clear_hist();
    start_run(1, 0, 0, 6, 1'b1);
    run(100, 1'b0, 40);
    foreach (hist[i]) check_eq("t6_lfsr_a", hist[i], want[i]);
    do_reset();
    clear_hist();
    start_run(1, 0, 0, 6, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_valid", tx_valid, 1'b0);
    check_eq("t6_async_busy", busy, 1'b0);
    check_eq("t6_async_count", tx_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 16'h0);
    clear_hist();
    start_run(1, 0, 0, 6, 1'b1);
    run(100, 1'b0, 40);
    check_eq("t6_restart_count", hist.size(), 6);
    foreach (hist[i]) check_eq("t6_lfsr_b", hist[i], want[i]);

    // Randomized runs with concurrent rx traffic
    for (int r = 0; r < 12; r++) begin
      start_run($urandom_range(3), $urandom_range(15), $urandom_range(3),
                $urandom_range(1, 10), 1'b1);
      run(70, 1'b1, 300);
      tick(1'b1, 1'b0, 1'b0, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
